frame_streamer: RTL

Source-side pixel streamer for the conv→ReLU→pool accelerator pipeline. Holds one signed 8-bit image in an on-chip frame buffer, loaded through a simple write port. On `start` it emits the image in raster order as a one-pixel-per-cycle `valid_out`/`pixel_out` stream, suitable for driving the pipeline's `valid_in`/`pixel_in`. Row and frame markers are provided for bench alignment.

---
 rtl/frame_streamer_if.sv | 36 +++
 rtl/frame_streamer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/frame_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_streamer_if
// Description : Load port, frame control and pixel stream bundle for the
//               frame_streamer source block.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_streamer_if #(
    parameter int ADDR_W = 10
) ();
    logic                     load_en;
    logic [ADDR_W-1:0]        load_addr;
    logic signed [7:0]        load_data;
    logic                     start;
    logic [7:0]               img_width;
    logic [7:0]               img_height;
    logic                     hold;
    logic signed [7:0]        pixel_out;
    logic                     valid_out;
    logic                     sof;
    logic                     eol;
    logic                     eof;
    logic                     busy;
    logic                     err;

    modport master (
        output load_en, load_addr, load_data, start, img_width, img_height, hold,
        input  pixel_out, valid_out, sof, eol, eof, busy, err
    );

    modport slave (
        input  load_en, load_addr, load_data, start, img_width, img_height, hold,
        output pixel_out, valid_out, sof, eol, eof, busy, err
    );
endinterface
`default_nettype wire

// File: rtl/frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : frame_streamer
// Description : Frame buffer plus raster-order pixel streamer with row/frame
//               markers. Optional inter-row idle gap: FRAME_STREAMER_ROW_GAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_streamer #(
    parameter int MAX_W   = 32,
    parameter int MAX_H   = 32,
    parameter int ADDR_W  = 10,
    parameter int ROW_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    frame_streamer_if.slave  bus
);

    localparam int         c_DEPTH   = MAX_W * MAX_H;
    localparam logic [7:0] c_MIN_DIM = 8'd3;
    localparam logic [7:0] c_MAX_W8  = 8'(MAX_W);
    localparam logic [7:0] c_MAX_H8  = 8'(MAX_H);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_STREAM = 2'd1;
    localparam logic [1:0] c_ST_GAP    = 2'd2;
    localparam logic [1:0] c_ST_DRAIN  = 2'd3;

`ifdef FRAME_STREAMER_ROW_GAP_EN
    localparam int              c_GAP_W    = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);
    localparam bit              c_GAP_ON   = (ROW_GAP > 0);
    logic [c_GAP_W-1:0]         r_gap_cnt;
`else
    // ROW_GAP has no effect when the gap option is not built.
    logic w_unused_row_gap;
    assign w_unused_row_gap = (ROW_GAP != 0);
`endif

    logic signed [7:0]  r_mem [c_DEPTH];

    logic [1:0]         r_state;
    logic [7:0]         r_w;
    logic [7:0]         r_h;
    logic [7:0]         r_x;
    logic [7:0]         r_y;
    logic [ADDR_W-1:0]  r_addr;

    logic signed [7:0]  r_pixel;
    logic               r_valid;
    logic               r_sof;
    logic               r_eol;
    logic               r_eof;
    logic               r_busy;
    logic               r_err;

    logic               w_dims_ok;
    logic               w_last_x;
    logic               w_last_y;

    assign w_dims_ok = (bus.img_width  >= c_MIN_DIM) && (bus.img_width  <= c_MAX_W8) &&
                       (bus.img_height >= c_MIN_DIM) && (bus.img_height <= c_MAX_H8);
    assign w_last_x  = (r_x == r_w - 8'd1);
    assign w_last_y  = (r_y == r_h - 8'd1);

    // Writes are accepted only while idle, so a read never collides with one.
    always_ff @(posedge clk) begin
        if (bus.load_en && (r_state == c_ST_IDLE)) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_w       <= 8'd0;
            r_h       <= 8'd0;
            r_x       <= 8'd0;
            r_y       <= 8'd0;
            r_addr    <= '0;
            r_pixel   <= 8'sd0;
            r_valid   <= 1'b0;
            r_sof     <= 1'b0;
            r_eol     <= 1'b0;
            r_eof     <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
`ifdef FRAME_STREAMER_ROW_GAP_EN
            r_gap_cnt <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        if (w_dims_ok) begin
                            r_w     <= bus.img_width;
                            r_h     <= bus.img_height;
                            r_x     <= 8'd0;
                            r_y     <= 8'd0;
                            r_addr  <= '0;
                            r_state <= c_ST_STREAM;
                            r_busy  <= 1'b1;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                end

                c_ST_STREAM: begin
                    if (!bus.hold) begin
                        // Read data and its markers land together one cycle later.
                        r_pixel <= r_mem[r_addr];
                        r_valid <= 1'b1;
                        r_sof   <= (r_x == 8'd0) && (r_y == 8'd0);
                        r_eol   <= w_last_x;
                        r_eof   <= w_last_x && w_last_y;
                        r_addr  <= r_addr + ADDR_W'(1);
                        if (w_last_x) begin
                            r_x <= 8'd0;
                            if (w_last_y) begin
                                r_state <= c_ST_DRAIN;
                            end else begin
                                r_y <= r_y + 8'd1;
`ifdef FRAME_STREAMER_ROW_GAP_EN
                                if (c_GAP_ON) begin
                                    r_state   <= c_ST_GAP;
                                    r_gap_cnt <= c_GAP_LOAD;
                                end
`endif
                            end
                        end else begin
                            r_x <= r_x + 8'd1;
                        end
                    end
                end

`ifdef FRAME_STREAMER_ROW_GAP_EN
                c_ST_GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= c_ST_STREAM;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
                    end
                end
`endif

                c_ST_DRAIN: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pixel_out = r_pixel;
    assign bus.valid_out = r_valid;
    assign bus.sof       = r_sof;
    assign bus.eol       = r_eol;
    assign bus.eof       = r_eof;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;

endmodule
`default_nettype wire
